// File: rtl/vx_avs_mem_responder.sv
// Avalon-MM responder: single-bank memory model answering avs_* read/write
// commands with fixed-latency in-order read returns, burst reads and
// outstanding-read throttling.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   avs_address         word address (upper bits beyond memory depth ignored)
//   avs_read/avs_write  command strobes
//   avs_writedata       write data
//   avs_byteenable      write byte mask
//   avs_burstcount      read beats (writes must be 1)
//   avs_waitrequest     command stall
//   avs_readdata        registered read data, holds last returned beat
//   avs_readdatavalid   read beat valid, no backpressure
//   pending_count       beats accepted but not yet returned
//   err_proto           sticky protocol-error flag
module vx_avs_mem_responder #(
    parameter int AVS_DATA_WIDTH  = 512,
    parameter int AVS_ADDR_WIDTH  = 26,
    parameter int AVS_BURST_WIDTH = 4,
    parameter int MEM_ADDR_WIDTH  = 10,
    parameter int READ_LATENCY    = 4,
    parameter int MAX_PENDING     = 8,
    localparam int AVS_BYTEENW    = AVS_DATA_WIDTH / 8,
    localparam int PEND_W         = $clog2(MAX_PENDING + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [AVS_ADDR_WIDTH-1:0]  avs_address,
    input  logic                       avs_read,
    input  logic                       avs_write,
    input  logic [AVS_DATA_WIDTH-1:0]  avs_writedata,
    input  logic [AVS_BYTEENW-1:0]     avs_byteenable,
    input  logic [AVS_BURST_WIDTH-1:0] avs_burstcount,
    output logic                       avs_waitrequest,
    output logic [AVS_DATA_WIDTH-1:0]  avs_readdata,
    output logic                       avs_readdatavalid,
    output logic [PEND_W-1:0]          pending_count,
    output logic                       err_proto
);

    localparam int DEPTH = 2 ** MEM_ADDR_WIDTH;

    typedef enum logic {
        IDLE,
        RBURST
    } state_t;

    state_t                      state;
    logic [AVS_BURST_WIDTH-1:0]  beats_left;
    logic [MEM_ADDR_WIDTH-1:0]   burst_addr;

    logic [AVS_DATA_WIDTH-1:0]   mem [DEPTH];

    logic [READ_LATENCY-1:0]     pipe_v;
    logic [AVS_DATA_WIDTH-1:0]   pipe_d [READ_LATENCY];

    logic [AVS_BURST_WIDTH-1:0]  b_eff;
    logic [31:0]                 need;
    logic                        throttle;
    logic                        cmd_acc;
    logic                        rd_acc;
    logic                        wr_acc;
    logic                        dual;
    logic                        bad_cmd;
    logic                        issue;
    logic [MEM_ADDR_WIDTH-1:0]   cmd_idx;
    logic [MEM_ADDR_WIDTH-1:0]   issue_addr;
    logic [PEND_W-1:0]           pend_next;

    logic unused_addr_hi;
    assign unused_addr_hi = ^avs_address[AVS_ADDR_WIDTH-1:MEM_ADDR_WIDTH];

    // burstcount 0 is an error but still behaves as a single beat
    assign b_eff = (avs_burstcount == '0)
                 ? AVS_BURST_WIDTH'(1) : avs_burstcount;

    assign need     = 32'(pending_count) + 32'(b_eff);
    assign throttle = avs_read && (need > 32'(MAX_PENDING));

    assign avs_waitrequest = reset | (state == RBURST) | throttle;

    assign dual    = avs_read && avs_write;
    assign cmd_acc = (avs_read || avs_write) && !avs_waitrequest;
    assign rd_acc  = cmd_acc && avs_read && !avs_write;
    assign wr_acc  = cmd_acc && avs_write && !avs_read;

    assign bad_cmd = dual
                   || (avs_write && avs_burstcount != AVS_BURST_WIDTH'(1))
                   || (avs_read && avs_burstcount == '0);

    assign cmd_idx    = avs_address[MEM_ADDR_WIDTH-1:0];
    assign issue      = rd_acc || (state == RBURST);
    assign issue_addr = (state == RBURST) ? burst_addr : cmd_idx;

    always_comb begin
        pend_next = PEND_W'(32'(pending_count)
                  + (rd_acc ? 32'(b_eff) : 32'd0)
                  - (avs_readdatavalid ? 32'd1 : 32'd0));
    end

    // Memory contents survive reset, so the array has no reset branch
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < AVS_BYTEENW; i++) begin
                if (avs_byteenable[i]) begin
                    mem[cmd_idx][i*8 +: 8] <= avs_writedata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            beats_left    <= '0;
            burst_addr    <= '0;
            pending_count <= '0;
            err_proto     <= 1'b0;
        end else begin
            pending_count <= pend_next;
            if (cmd_acc && bad_cmd) begin
                err_proto <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (rd_acc && b_eff > AVS_BURST_WIDTH'(1)) begin
                        state      <= RBURST;
                        beats_left <= b_eff - AVS_BURST_WIDTH'(1);
                        burst_addr <= issue_addr + MEM_ADDR_WIDTH'(1);
                    end
                end
                RBURST: begin
                    burst_addr <= burst_addr + MEM_ADDR_WIDTH'(1);
                    beats_left <= beats_left - AVS_BURST_WIDTH'(1);
                    if (beats_left == AVS_BURST_WIDTH'(1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Latency pipeline: data is captured at issue; each stage only loads
    // when the stage before it is valid, so the last stage holds the most
    // recently returned beat while the valid bit is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_v <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= issue;
            if (issue) begin
                pipe_d[0] <= mem[issue_addr];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                if (pipe_v[i-1]) begin
                    pipe_d[i] <= pipe_d[i-1];
                end
            end
        end
    end

    assign avs_readdatavalid = pipe_v[READ_LATENCY-1];
    assign avs_readdata      = pipe_d[READ_LATENCY-1];

endmodule

// File: tb/tb_vx_avs_mem_responder.sv
// Self-checking bench for vx_avs_mem_responder: scoreboard of expected
// read beats (data and return cycle) against a bench-side memory model.
module tb_vx_avs_mem_responder;

    localparam int DW   = 512;
    localparam int AW   = 26;
    localparam int BW   = 4;
    localparam int MA   = 10;
    localparam int LAT  = 4;
    localparam int MAXP = 8;
    localparam int BEW  = DW / 8;
    localparam int PW   = $clog2(MAXP + 1);
    localparam int DEP  = 2 ** MA;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] avs_address = '0;
    logic          avs_read = 1'b0;
    logic          avs_write = 1'b0;
    logic [DW-1:0] avs_writedata = '0;
    logic [BEW-1:0] avs_byteenable = '0;
    logic [BW-1:0] avs_burstcount = '0;
    logic          avs_waitrequest;
    logic [DW-1:0] avs_readdata;
    logic          avs_readdatavalid;
    logic [PW-1:0] pending_count;
    logic          err_proto;

    vx_avs_mem_responder #(
        .AVS_DATA_WIDTH (DW),
        .AVS_ADDR_WIDTH (AW),
        .AVS_BURST_WIDTH(BW),
        .MEM_ADDR_WIDTH (MA),
        .READ_LATENCY   (LAT),
        .MAX_PENDING    (MAXP)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .avs_address      (avs_address),
        .avs_read         (avs_read),
        .avs_write        (avs_write),
        .avs_writedata    (avs_writedata),
        .avs_byteenable   (avs_byteenable),
        .avs_burstcount   (avs_burstcount),
        .avs_waitrequest  (avs_waitrequest),
        .avs_readdata     (avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .pending_count    (pending_count),
        .err_proto        (err_proto)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] mdl [int];
    exp_t          mon_e;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int peak = 0;
    int post_cnt = 0;
    bit pchk = 1'b0;
    bit post_rst = 1'b0;

    localparam logic [BEW-1:0] BE_ALL = '1;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int a);
        return {16{16'(a), 16'hC35A}};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Return monitor: every valid beat must match the head of the queue
    always @(negedge clk) begin
        if (!reset && avs_readdatavalid) begin
            if (post_rst) post_cnt++;
            if (q.size() == 0) begin
                chk("unexp_rdv", 1, 0);
            end else begin
                mon_e = q.pop_front();
                chk("rdata", avs_readdata, mon_e.data);
                chk("rlat", DW'(cyc), DW'(mon_e.cyc));
            end
        end
    end

    // Outstanding beats in the queue must equal pending_count
    always @(posedge clk) begin
        #2;
        if (pchk) begin
            chk("pend", DW'(pending_count), DW'(q.size()));
            if (int'(pending_count) > peak) peak = int'(pending_count);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept cycle
    task automatic send(input bit rd, input bit wr,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] wd,
                        input logic [BEW-1:0] be,
                        input logic [BW-1:0] bc,
                        output int acc);
        int            idx;
        int            b;
        logic [DW-1:0] w;
        avs_read       = rd;
        avs_write      = wr;
        avs_address    = a;
        avs_writedata  = wd;
        avs_byteenable = be;
        avs_burstcount = bc;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!avs_waitrequest) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            chk("accept_timeout", 1, 0);
        end else if (rd && wr) begin
            acc = acc;
        end else if (wr) begin
            idx = int'(a[MA-1:0]);
            w = mdl.exists(idx) ? mdl[idx] : '0;
            for (int i = 0; i < BEW; i++) begin
                if (be[i]) w[i*8 +: 8] = wd[i*8 +: 8];
            end
            mdl[idx] = w;
        end else if (rd) begin
            idx = int'(a[MA-1:0]);
            b = (bc == '0) ? 1 : int'(bc);
            for (int k = 0; k < b; k++) begin
                exp_t e;
                e.data = mdl[(idx + k) % DEP];
                e.cyc  = acc + k + LAT;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) chk("drain_timeout", DW'(q.size()), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int a1, a2, a3;

        repeat (3) @(negedge clk);
        chk("rst_wreq", DW'(avs_waitrequest), 1);
        chk("rst_rdv", DW'(avs_readdatavalid), 0);
        chk("rst_rdata", avs_readdata, 0);
        chk("rst_pend", DW'(pending_count), 0);
        chk("rst_err", DW'(err_proto), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pchk  = 1'b1;
        @(posedge clk);
        #1;

        // Full write then single read
        send(0, 1, 3, {64{8'hA5}}, BE_ALL, 1, a1);
        send(1, 0, 3, '0, '0, 1, a1);
        drain();

        // Partial byte write, readdata holds afterwards
        send(0, 1, 5, '0, BE_ALL, 1, a1);
        send(0, 1, 5, {DW{1'b1}}, BEW'(1), 1, a1);
        send(1, 0, 5, '0, '0, 1, a1);
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("rd_hold", avs_readdata, DW'(8'hFF));
        chk("rdv_idle", DW'(avs_readdatavalid), 0);

        // Wrapping burst; upper address bits ignored
        send(0, 1, 26'd1022, pat(1022), BE_ALL, 1, a1);
        send(0, 1, 26'd1023, pat(1023), BE_ALL, 1, a1);
        send(0, 1, 26'h400, pat(0), BE_ALL, 1, a1);
        send(0, 1, 26'h401, pat(1), BE_ALL, 1, a1);
        send(1, 0, 26'h2003FE, '0, '0, 4, a1);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("burst_wreq", DW'(avs_waitrequest), 1);
        end
        @(negedge clk);
        chk("burst_free", DW'(avs_waitrequest), 0);
        @(posedge clk);
        #1;
        drain();

        for (int i = 7; i < 42; i++) begin
            send(0, 1, AW'(i), pat(i), BE_ALL, 1, a1);
        end

        // Back-to-back bursts
        send(1, 0, 30, '0, '0, 4, a1);
        send(1, 0, 34, '0, '0, 4, a2);
        send(1, 0, 38, '0, '0, 4, a3);
        chk("b2b_acc2", DW'(a2), DW'(a1 + 4));
        chk("b2b_acc3", DW'(a3), DW'(a1 + 8));
        drain();

        // Throttle: 8-beat read waits for the first burst to drain
        peak = 0;
        send(1, 0, 10, '0, '0, 4, a1);
        send(1, 0, 20, '0, '0, 8, a2);
        chk("thr_acc", DW'(a2), DW'(a1 + 8));
        drain();
        chk("thr_peak", DW'(peak), DW'(MAXP));

        // Protocol errors
        chk("err_clear", DW'(err_proto), 0);
        send(0, 1, 7, {64{8'h3C}}, BE_ALL, 2, a1);
        chk("err_wr_bc", DW'(err_proto), 1);
        send(1, 0, 7, '0, '0, 1, a1);
        drain();
        send(1, 1, 8, {64{8'hEE}}, BE_ALL, 1, a1);
        repeat (LAT + 4) @(posedge clk);
        #1;
        chk("dual_pend", DW'(pending_count), 0);
        chk("err_sticky", DW'(err_proto), 1);
        send(1, 0, 8, '0, '0, 1, a1);
        drain();

        // Reset mid-burst
        send(1, 0, 10, '0, '0, 4, a1);
        @(posedge clk);
        #1;
        pchk = 1'b0;
        q.delete();
        reset = 1'b1;
        #1;
        chk("mid_rst_wreq", DW'(avs_waitrequest), 1);
        chk("mid_rst_pend", DW'(pending_count), 0);
        chk("mid_rst_rdv", DW'(avs_readdatavalid), 0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("mid_rst_wreq_hold", DW'(avs_waitrequest), 1);
        end
        @(posedge clk);
        #1;
        reset    = 1'b0;
        post_cnt = 0;
        post_rst = 1'b1;
        pchk     = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("post_rst_rdv", DW'(post_cnt), 0);
        chk("post_rst_pend", DW'(pending_count), 0);
        chk("post_rst_err", DW'(err_proto), 0);
        chk("post_rst_rdata", avs_readdata, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
